// File: rtl/nubus_pkg.sv
// nubus_pkg: shared types and constants for the NuBus slot initiator.
//   nubus_state_t  - handshake FSM states
//   SLOT_SPACE_HI  - upper nibble of every slot window address
//   ADDR_W/DATA_W/BE_W - CPU and card bus widths
package nubus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    localparam logic [3:0] SLOT_SPACE_HI = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RECOVER = 2'd3
    } nubus_state_t;

endpackage

// File: rtl/nubus_irq_sync.sv
// nubus_irq_sync: brings the card's asynchronous nmrq_n into the clk domain.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   nmrq_n      - card interrupt request, active-low, asynchronous
//   irq         - synchronised request level, active-high
//   irq_re      - one-cycle pulse on the rising edge of irq
module nubus_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic nmrq_n,
    output logic irq,
    output logic irq_re
);

    logic sync_p0;
    logic sync_p1;
    logic irq_prev_p2;

    // Sync flops reset to the inactive (high) level so no spurious request leaves reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0     <= 1'b1;
            sync_p1     <= 1'b1;
            irq_prev_p2 <= 1'b0;
        end else begin
            sync_p0     <= nmrq_n;
            sync_p1     <= sync_p0;
            irq_prev_p2 <= ~sync_p1;
        end
    end

    assign irq    = ~sync_p1;
    assign irq_re = irq & ~irq_prev_p2;

endmodule

// File: rtl/nubus_slot_initiator.sv
// nubus_slot_initiator: converts one CPU bus cycle aimed at the slot window into a
// select/ack_n handshake with the slot card, returning read data and DTACK, or a bus
// error if the card never answers. Also synchronises the card interrupt.
// Ports:
//   clk, reset                    - system clock, asynchronous active-high reset
//   cpu_req/addr/wdata/be/rw_n    - CPU cycle request (level held until ack/berr)
//   cpu_rdata/ack/berr            - CPU response, held until cpu_req falls
//   cpu_hit                       - combinational window decode of the current request
//   nb_addr/wdata/be/rw_n/select  - registered card-side request
//   nb_rdata, nb_ack_n            - card response
//   nb_nmrq_n                     - card interrupt request (async, active-low)
//   slot_irq, slot_irq_re         - synchronised interrupt level and rising-edge pulse
module nubus_slot_initiator
    import nubus_pkg::*;
#(
    parameter logic [3:0]  SLOT_ID     = 4'h9,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_be,
    input  logic              cpu_rw_n,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_berr,
    output logic              cpu_hit,
    output logic [ADDR_W-1:0] nb_addr,
    output logic [DATA_W-1:0] nb_wdata,
    output logic [BE_W-1:0]   nb_be,
    output logic              nb_rw_n,
    output logic              nb_select,
    input  logic [DATA_W-1:0] nb_rdata,
    input  logic              nb_ack_n,
    input  logic              nb_nmrq_n,
    output logic              slot_irq,
    output logic              slot_irq_re
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    nubus_state_t      state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic [BE_W-1:0]   be_d;
    logic              rw_n_d, select_d, ack_d, berr_d;

    assign cpu_hit = cpu_req && (cpu_addr[ADDR_W-1 -: 8] == {SLOT_SPACE_HI, SLOT_ID});

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        addr_d   = nb_addr;
        wdata_d  = nb_wdata;
        be_d     = nb_be;
        rw_n_d   = nb_rw_n;
        select_d = nb_select;
        rdata_d  = cpu_rdata;
        ack_d    = cpu_ack;
        berr_d   = cpu_berr;
        case (state_q)
            IDLE: begin
                // Card-side request is only ever loaded here, so it stays stable under select.
                if (cpu_hit) begin
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    be_d     = cpu_be;
                    rw_n_d   = cpu_rw_n;
                    select_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (timer_q != TMR_MAX)
                    timer_d = timer_q + 1'b1;
                // A CPU that has left the cycle gets no response, even if the card answers now.
                if (!cpu_req) begin
                    select_d = 1'b0;
                    state_d  = RECOVER;
                end else if (!nb_ack_n) begin
                    if (nb_rw_n)
                        rdata_d = nb_rdata;
                    ack_d    = 1'b1;
                    select_d = 1'b0;
                    state_d  = DONE;
                end else if (timer_q == TMR_LAST) begin
                    berr_d   = 1'b1;
                    select_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!cpu_req) begin
                    ack_d   = 1'b0;
                    berr_d  = 1'b0;
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                // Let the card release ack_n before a new select can start.
                if (nb_ack_n)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            nb_addr   <= '0;
            nb_wdata  <= '0;
            nb_be     <= '0;
            nb_rw_n   <= 1'b1;
            nb_select <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_berr  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            nb_addr   <= addr_d;
            nb_wdata  <= wdata_d;
            nb_be     <= be_d;
            nb_rw_n   <= rw_n_d;
            nb_select <= select_d;
            cpu_rdata <= rdata_d;
            cpu_ack   <= ack_d;
            cpu_berr  <= berr_d;
        end
    end

    nubus_irq_sync u_irq_sync (
        .clk    (clk),
        .reset  (reset),
        .nmrq_n (nb_nmrq_n),
        .irq    (slot_irq),
        .irq_re (slot_irq_re)
    );

endmodule
